apb_periph_router: RTL and testbench

- Parametrised successor of the SoC peripheral APB node: one upstream APB slave port fanned out to NB_MASTER downstream APB master ports, selected by per-port address windows.
- Adds a registered decode stage, a decode-error response for unmapped addresses, a per-access PREADY timeout with error response, and saturating error counters.
- Sits between the AXI-to-APB bridge and the peripherals (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, debug, SPI accel, 7-segment and later additions).

---
 rtl/apb_periph_router.sv | 196 +++++++++++++++++++
 tb/tb_apb_periph_router.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_periph_router.sv
// apb_periph_router: one upstream APB slave fanned out to NB_MASTER APB master
// ports by per-port inclusive address windows. The decode is registered. An
// unmapped address gets an error response, and so does a stalled access once
// its PREADY timeout expires. Both kinds of error are counted in saturating
// counters.
//
// state  | meaning
// IDLE   | waiting for an upstream setup phase; decode evaluated here
// SETUP  | downstream PSEL asserted, PENABLE low
// ACCESS | downstream PSEL+PENABLE, waiting for PREADY or timeout
// ERR    | unmapped address, no downstream select
// RESP   | one-cycle upstream PREADY with the captured result
module apb_periph_router #(
  parameter int NB_MASTER      = 11,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  input  logic [NB_MASTER-1:0]                     port_en_i,
  input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                pwdata_i,
  input  logic                                     pwrite_i,
  input  logic                                     psel_i,
  input  logic                                     penable_i,
  output logic [APB_DATA_WIDTH-1:0]                prdata_o,
  output logic                                     pready_o,
  output logic                                     pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]                m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                m_pwdata_o,
  output logic                                     m_pwrite_o,
  output logic                                     m_penable_o,
  output logic [NB_MASTER-1:0]                     m_psel_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_MASTER-1:0]                     m_pready_i,
  input  logic [NB_MASTER-1:0]                     m_pslverr_i,
  output logic [ERR_CNT_WIDTH-1:0]                 dec_err_cnt_o,
  output logic [ERR_CNT_WIDTH-1:0]                 tmo_err_cnt_o,
  output logic                                     busy_o
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW:0] TMO_LIM = (TW+1)'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR, S_RESP} state_t;

  state_t                    r_state;
  logic [NB_MASTER-1:0]      r_sel;
  logic [NB_MASTER-1:0]      r_psel;
  logic                      r_penable;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic [APB_DATA_WIDTH-1:0] r_prdata;
  logic                      r_pready;
  logic                      r_pslverr;
  logic                      r_busy;
  logic [TW-1:0]             r_tmo;
  logic [ERR_CNT_WIDTH-1:0]  r_dec_cnt;
  logic [ERR_CNT_WIDTH-1:0]  r_tmo_cnt;

  logic                      w_hit;
  logic [NB_MASTER-1:0]      w_onehot;
  logic                      w_ready;
  logic                      w_slverr;
  logic [APB_DATA_WIDTH-1:0] w_rdata;
  logic                      w_tmo_hit;

  // Window decode; scanning from the top down lets the lowest hitting index win.
  always_comb begin
    w_hit    = 1'b0;
    w_onehot = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if (port_en_i[i] && (paddr_i >= start_addr_i[i]) && (paddr_i <= end_addr_i[i])) begin
        w_hit       = 1'b1;
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Response mux from the latched port. The select is one-hot, so no index arithmetic is needed.
  always_comb begin
    w_ready  = 1'b0;
    w_slverr = 1'b0;
    w_rdata  = '0;
    for (int i = 0; i < NB_MASTER; i++) begin
      if (r_sel[i]) begin
        w_ready  = m_pready_i[i];
        w_slverr = m_pslverr_i[i];
        w_rdata  = m_prdata_i[i];
      end
    end
    // The count is compared one ahead, so the limit fires on the TIMEOUT_CYCLES-th ACCESS cycle.
    w_tmo_hit = (TIMEOUT_CYCLES != 0) && (({1'b0, r_tmo} + 1'b1) == TMO_LIM);
  end

  // Main FSM. Every output is a register that is updated together with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_busy    <= 1'b0;
      r_tmo     <= '0;
      r_dec_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            r_paddr  <= paddr_i;
            r_pwdata <= pwdata_i;
            r_pwrite <= pwrite_i;
            r_busy   <= 1'b1;
            if (w_hit) begin
              r_sel     <= w_onehot;
              r_psel    <= w_onehot;
              r_penable <= 1'b0;
              r_tmo     <= '0;
              r_state   <= S_SETUP;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_ready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pready  <= 1'b1;
            r_pslverr <= w_slverr;
            r_prdata  <= r_pwrite ? '0 : w_rdata;
            r_state   <= S_RESP;
          end else if (w_tmo_hit) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_ERR: begin
          r_pready  <= 1'b1;
          r_pslverr <= 1'b1;
          if (r_dec_cnt != '1) r_dec_cnt <= r_dec_cnt + 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign prdata_o      = r_prdata;
  assign pready_o      = r_pready;
  assign pslverr_o     = r_pslverr;
  assign m_paddr_o     = r_paddr;
  assign m_pwdata_o    = r_pwdata;
  assign m_pwrite_o    = r_pwrite;
  assign m_penable_o   = r_penable;
  assign m_psel_o      = r_psel;
  assign dec_err_cnt_o = r_dec_cnt;
  assign tmo_err_cnt_o = r_tmo_cnt;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_apb_periph_router.sv
// Bench for apb_periph_router. Expected responses go into a scoreboard queue
// when each transfer is launched. A negedge monitor pops an entry whenever
// pready_o is high and checks data, error and arrival cycle.
// The timeout is set to 5, so a slave with 4 wait states answers on the limit cycle.
module tb_apb_periph_router;

  localparam int NB  = 11;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 5;
  localparam int ECW = 8;

  logic                   clk;
  logic                   rst;
  logic [NB-1:0][AW-1:0]  start_addr;
  logic [NB-1:0][AW-1:0]  end_addr;
  logic [NB-1:0]          port_en;
  logic [AW-1:0]          paddr;
  logic [DW-1:0]          pwdata;
  logic                   pwrite, psel, penable;
  logic [DW-1:0]          prdata;
  logic                   pready, pslverr;
  logic [AW-1:0]          m_paddr;
  logic [DW-1:0]          m_pwdata;
  logic                   m_pwrite, m_penable;
  logic [NB-1:0]          m_psel;
  logic [NB-1:0][DW-1:0]  m_prdata;
  logic [NB-1:0]          m_pready, m_pslverr;
  logic [ECW-1:0]         dec_cnt, tmo_cnt;
  logic                   busy;

  apb_periph_router #(
    .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .start_addr_i(start_addr), .end_addr_i(end_addr), .port_en_i(port_en),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite), .psel_i(psel), .penable_i(penable),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata), .m_pwrite_o(m_pwrite),
    .m_penable_o(m_penable), .m_psel_o(m_psel),
    .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
    .dec_err_cnt_o(dec_cnt), .tmo_err_cnt_o(tmo_cnt), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Slave model: per-port wait states, stuck-not-ready flag, error flag and read data.
  int            wait_st[NB];
  int            acc_cnt[NB];
  logic [NB-1:0] never_rdy;
  logic [NB-1:0] slv_err;
  logic [DW-1:0] rdata[NB];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NB; i++) begin
      if (rst) acc_cnt[i] <= 0;
      else if (m_psel[i] && m_penable) acc_cnt[i] <= acc_cnt[i] + 1;
      else acc_cnt[i] <= 0;
    end
  end

  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    for (int i = 0; i < NB; i++) begin
      m_pready[i]  = m_psel[i] && m_penable && !never_rdy[i] && (acc_cnt[i] >= wait_st[i]);
      m_pslverr[i] = slv_err[i];
      m_prdata[i]  = rdata[i];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  // Response monitor: every upstream PREADY must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && pready) begin
      if (sb.size() == 0) begin
        chk("spurious_pready", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("prdata", prdata, e.data);
        chk("pslverr", pslverr, e.err);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic wr,
                      input logic [NB-1:0] exp_sel, input logic [DW-1:0] exp_data,
                      input logic exp_err, input int lat);
    exp_t          e;
    logic [NB-1:0] seen;
    int            n;
    @(negedge clk);
    paddr = addr; pwdata = wdata; pwrite = wr; psel = 1'b1; penable = 1'b0;
    e.data = exp_data; e.err = exp_err; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    chk("busy_setup", busy, 1);
    chk("sel_setup", m_psel, exp_sel);
    chk("penable_setup", m_penable, 0);
    if (exp_sel != '0) begin
      chk("m_paddr", m_paddr, addr);
      chk("m_pwdata", m_pwdata, wdata);
      chk("m_pwrite", m_pwrite, wr);
    end
    seen = m_psel;
    n = 0;
    while (!pready && n < 40) begin
      @(negedge clk);
      seen |= m_psel;
      n++;
    end
    chk("pready_seen", pready, 1);
    chk("sel_union", seen, exp_sel);
    chk("sel_resp", m_psel, 0);
    chk("penable_resp", m_penable, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("pready_idle", pready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    port_en = '1; never_rdy = '0; slv_err = '0;
    for (int i = 0; i < NB; i++) begin
      start_addr[i] = 32'h1A0F_F000 + 32'(i) * 32'h1000;
      end_addr[i]   = start_addr[i] + 32'h0FFF;
      wait_st[i]    = 0;
      rdata[i]      = 32'hA500_0000 | 32'(i);
    end
    rdata[1]     = 32'hDEAD_BEEF;
    never_rdy[0] = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_psel", m_psel, 0);
    chk("rst_penable", m_penable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dec_cnt", dec_cnt, 0);
    chk("rst_tmo_cnt", tmo_cnt, 0);
    rst = 1'b0;

    // zero-wait read on port 1
    xfer(32'h1A10_0000, 32'h0, 1'b0, 11'h002, 32'hDEAD_BEEF, 1'b0, 3);
    // write to port 3 with 4 wait states; ready coincides with the timeout limit
    wait_st[3] = 4;
    xfer(32'h1A10_2010, 32'h1234_5678, 1'b1, 11'h008, 32'h0, 1'b0, 7);
    chk("tmo_cnt_pready_wins", tmo_cnt, 0);
    // write returns zero data even though the slave drives read data
    xfer(32'h1A10_0004, 32'hCAFE_0001, 1'b1, 11'h002, 32'h0, 1'b0, 3);
    // unmapped address
    xfer(32'h3000_0000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 2);
    chk("dec_cnt_1", dec_cnt, 1);
    // window edges, unsigned compare
    xfer(32'h1A10_9FFF, 32'h0, 1'b0, 11'h400, 32'hA500_000A, 1'b0, 3);
    xfer(32'h1A0F_F000, 32'h0, 1'b1, 11'h001, 32'h0, 1'b1, 7);
    chk("tmo_cnt_1", tmo_cnt, 1);
    xfer(32'h1A0F_EFFF, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 2);
    xfer(32'h1A10_A000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 2);
    xfer(32'hFFFF_FFFF, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 2);
    chk("dec_cnt_4", dec_cnt, 4);
    // slave error with 2 wait states
    wait_st[6] = 2; slv_err[6] = 1'b1;
    xfer(32'h1A10_5000, 32'h0, 1'b0, 11'h040, 32'hA500_0006, 1'b1, 5);
    // disabled port never decodes
    port_en[7] = 1'b0;
    xfer(32'h1A10_6004, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 2);
    chk("dec_cnt_5", dec_cnt, 5);
    port_en[7] = 1'b1;
    // timeout saturation: 299 more timeouts on top of the first
    for (int k = 0; k < 299; k++)
      xfer(32'h1A0F_F100, 32'h0, 1'b0, 11'h001, 32'h0, 1'b1, 7);
    chk("tmo_cnt_sat", tmo_cnt, 255);
    // overlapping windows: lowest index wins, then disabling it exposes port 5
    start_addr[5] = 32'h1A10_1000; end_addr[5] = 32'h1A10_1FFF;
    xfer(32'h1A10_1800, 32'h0, 1'b0, 11'h004, 32'hA500_0002, 1'b0, 3);
    port_en[2] = 1'b0;
    xfer(32'h1A10_1800, 32'h0, 1'b0, 11'h020, 32'hA500_0005, 1'b0, 3);
    port_en[2] = 1'b1;

    // reset asserted while in ACCESS on the never-ready port
    @(negedge clk);
    paddr = 32'h1A0F_F200; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("mid_access_penable", m_penable, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_psel", m_psel, 0);
    chk("mid_rst_penable", m_penable, 0);
    chk("mid_rst_pready", pready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tmo_cnt", tmo_cnt, 0);
    chk("mid_rst_dec_cnt", dec_cnt, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    xfer(32'h1A10_0040, 32'h0, 1'b0, 11'h002, 32'hDEAD_BEEF, 1'b0, 3);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
